// File: rtl/game_pkg.sv
// Shared definitions for the game input front end: debounce FSM encoding,
// button indices (which also fix the command priority) and gameFSM state codes.
package game_pkg;

  // Debounce FSM state encoding.
  typedef enum logic [1:0] {
    IDLE_UP   = 2'd0,
    CNT_DOWN  = 2'd1,
    HELD_DOWN = 2'd2,
    CNT_UP    = 2'd3
  } deb_state_e;

  // Button indices; a lower index wins when press events coincide.
  localparam int BTN_RESET = 0;
  localparam int BTN_START = 1;
  localparam int BTN_PAUSE = 2;
  localparam int NUM_BTN   = 3;

  // Downstream gameFSM state codes, for benches that follow the game state.
  typedef enum logic [2:0] {
    START    = 3'b000,
    PLAYING  = 3'b001,
    PAUSE    = 3'b010,
    RESET    = 3'b011,
    GAMEOVER = 3'b100
  } game_state_e;

endpackage

// File: rtl/button_debounce.sv
// One push button: 2-flop synchronizer followed by a debounce FSM that emits
// a single registered pressEvt per accepted press. Release is debounced but
// silent. A button must be seen released after reset before a press counts.
module button_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic resetFSM,
  input  logic btnRaw,
  output logic pressEvt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [1:0]       vld_q, vld_d;
  logic             armed_q, armed_d;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_evt_q, press_evt_d;
  logic             lvl;

  // Synchronized, active-low button level (0 = pressed).
  assign lvl = sync_q[1];

  // Synchronizer shift plus arming: vld_q marks when sync_q[1] holds a real
  // sample rather than its reset value; the button arms once that real sample
  // reads released, so a button held through reset is ignored.
  always_comb begin
    sync_d  = {sync_q[0], btnRaw};
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & lvl);
  end

  // Next-state and counter: count consecutive stable samples in each direction.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE_UP: begin
        if (armed_q && !lvl) begin
          state_d = CNT_DOWN;
          cnt_d   = '0;
        end
      end
      CNT_DOWN: begin
        if (lvl) begin
          state_d = IDLE_UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD_DOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD_DOWN: begin
        if (lvl) begin
          state_d = CNT_UP;
          cnt_d   = '0;
        end
      end
      CNT_UP: begin
        if (!lvl) begin
          state_d = HELD_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_UP;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: one event on the cycle the press count completes.
  always_comb begin
    press_evt_d = (state_q == CNT_DOWN) && !lvl && (cnt_q == CNT_MAX);
  end

  // State register with synchronous active-low reset; sync flops reset to released.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!resetFSM) begin
      sync_q      <= 2'b11;
      vld_q       <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= IDLE_UP;
      cnt_q       <= '0;
      press_evt_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      vld_q       <= vld_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_evt_q <= press_evt_d;
    end
  end

  assign pressEvt = press_evt_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Game input front end: three debounced buttons, fixed-priority arbiter
// (reset > start > pause) and registered command outputs for gameFSM.
// Define GAME_PAUSE_TOGGLE_EN to make pauseGame a toggling level that is
// cleared by reset/start; otherwise pauseGame is a one-cycle strobe.
module game_input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic resetFSM,
  input  logic btnStart,
  input  logic btnPause,
  input  logic btnReset,
  output logic startGame,
  output logic pauseGame,
  output logic reset
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press_evt;
  logic               start_q, start_d;
  logic               pause_q, pause_d;
  logic               reset_q, reset_d;
  logic               pause_hit;

  assign btn_raw[BTN_RESET] = btnReset;
  assign btn_raw[BTN_START] = btnStart;
  assign btn_raw[BTN_PAUSE] = btnPause;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .resetFSM(resetFSM),
      .btnRaw  (btn_raw[i]),
      .pressEvt(press_evt[i])
    );
  end

  // Arbiter: highest-priority event wins, coincident lower ones are dropped.
  always_comb begin
    reset_d   = press_evt[BTN_RESET];
    start_d   = press_evt[BTN_START] & ~press_evt[BTN_RESET];
    pause_hit = press_evt[BTN_PAUSE] & ~press_evt[BTN_RESET] & ~press_evt[BTN_START];
`ifdef GAME_PAUSE_TOGGLE_EN
    if (reset_d || start_d) begin
      pause_d = 1'b0;
    end else if (pause_hit) begin
      pause_d = ~pause_q;
    end else begin
      pause_d = pause_q;
    end
`else
    pause_d = pause_hit;
`endif
  end

  // Registered command outputs.
  always_ff @(posedge clk) begin
    if (!resetFSM) begin
      start_q <= 1'b0;
      pause_q <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      start_q <= start_d;
      pause_q <= pause_d;
      reset_q <= reset_d;
    end
  end

  assign startGame = start_q;
  assign pauseGame = pause_q;
  assign reset     = reset_q;

endmodule
